dma_reg_slave: RTL and testbench
================================

DMA_REG_SLAVE -- requirements
Module: dma_reg_slave

Interface
REQ-001 The block SHALL have the following ports (name direction width meaning):
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wr_en  input  1  register write strobe, one write per cycle asserted.
REQ-005 rd_en  input  1  register read strobe, one read per cycle asserted.
REQ-006 addr  input  32  byte address of the register; only word-aligned map entries decode.
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  registered read data.
REQ-009 irq  output  1  interrupt, high while (intr_status & intr_mask) != 0.
REQ-010 Parameter BASE, default 32'h400, register map base address.

Function
REQ-011 Register map (offset from BASE): 0x00 INTR, 0x04 CTRL, 0x08 IO_ADDR, 0x0C MEM_ADDR, 0x10 EXTRA_INFO, 0x14 STATUS, 0x18 XFER_COUNT, 0x1C ERR_STATUS.
REQ-012 INTR: [15:0] intr_status RO, W1C; [31:16] intr_mask RW.
REQ-013 CTRL: [0] start (reads 0, write 1 launches transfer); [15:1] w_count RW; [16] io_mem RW; [31:17] reserved, read 0.
REQ-014 IO_ADDR, MEM_ADDR, EXTRA_INFO: full 32-bit RW.
REQ-015 STATUS RO: [0] busy, [1] done, [2] error, [4:3] engine state encoding; other bits 0.
REQ-016 XFER_COUNT RO: [15:0] words transferred in current/last transfer, upper bits 0.
REQ-017 ERR_STATUS W1C: [0] unmapped access, [1] write to CTRL/IO_ADDR/MEM_ADDR while busy, [2] start with w_count==0.
REQ-018 Write: on posedge with wr_en=1, decoded register updated; takes effect the same edge.
REQ-019 Read: on posedge with rd_en=1, rdata loads the decoded value; visible the cycle after rd_en, held until next read.
REQ-020 rd_en and wr_en same cycle, same address: rdata returns the pre-write value; write still performed.
REQ-021 Unmapped or misaligned address: read returns 0, write ignored, ERR_STATUS[0] set.
REQ-022 Engine states: IDLE (2'b00), RUN (2'b01), DONE (2'b10), ERROR (2'b11).
REQ-023 IDLE/DONE/ERROR -> RUN on CTRL write with wdata[0]=1 and wdata[15:1]!=0; XFER_COUNT cleared to 0, done and error cleared, busy set.
REQ-024 Start with wdata[15:1]==0: -> ERROR, ERR_STATUS[2] set, intr_status[1] set; w_count still updated.
REQ-025 RUN: XFER_COUNT increments by 1 per cycle; when XFER_COUNT+1 == w_count, -> DONE the same edge, busy cleared, done set, intr_status[0] set.
REQ-026 Transfer of N words: busy high exactly N cycles after the start-write edge.
REQ-027 Writes to CTRL, IO_ADDR, MEM_ADDR while busy: ignored, ERR_STATUS[1] set; other registers writable.
REQ-028 W1C of a status bit in the same cycle the engine sets it: set wins.
REQ-029 XFER_COUNT 16-bit, never wraps (max w_count is 32767).

Reset
REQ-030 rst_n low asynchronously forces all registers, XFER_COUNT, rdata to 0, state to IDLE, irq to 0, including mid-transfer; no transfer resumes after release.

Verification
REQ-031 Reset, read all 8 offsets -> every rdata 0, irq 0.
REQ-032 Write 32'hDEAD_BEEF to IO_ADDR, read back -> 32'hDEAD_BEEF one cycle after rd_en.
REQ-033 Write INTR=32'h0001_0000, CTRL=32'h0000_0009 (w_count 4) -> busy 4 cycles, STATUS=32'h0000_0012, XFER_COUNT=4, irq 1; W1C INTR bit0 -> irq 0.
REQ-034 Write CTRL=32'h1 -> STATUS=32'h0000_001C, ERR_STATUS=32'h4.
REQ-035 Read BASE+0x40 -> rdata 0, ERR_STATUS[0]=1; write MEM_ADDR during RUN -> value unchanged, ERR_STATUS[1]=1.
REQ-036 Assert rst_n low during RUN at XFER_COUNT=2 -> all reads 0, state IDLE after release.

Source files
------------

// File: rtl/dma_reg_slave.sv
// Memory-mapped register slave for a simple DMA engine: eight word registers
// at BASE, a word-counting transfer engine, and a level interrupt.
module dma_reg_slave #(
  parameter logic [31:0] BASE = 32'h400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DONE  = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  localparam logic [2:0] R_INTR   = 3'd0;
  localparam logic [2:0] R_CTRL   = 3'd1;
  localparam logic [2:0] R_IOADDR = 3'd2;
  localparam logic [2:0] R_MEMADR = 3'd3;
  localparam logic [2:0] R_EXTRA  = 3'd4;
  localparam logic [2:0] R_STATUS = 3'd5;
  localparam logic [2:0] R_XCOUNT = 3'd6;
  localparam logic [2:0] R_ERR    = 3'd7;

  state_t      state_q, state_d;
  logic [15:0] intr_status_q, intr_status_d;
  logic [15:0] intr_mask_q, intr_mask_d;
  logic [14:0] w_count_q, w_count_d;
  logic        io_mem_q, io_mem_d;
  logic [31:0] io_addr_q, io_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] extra_info_q, extra_info_d;
  logic [15:0] xfer_count_q, xfer_count_d;
  logic [2:0]  err_status_q, err_status_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] off;
  logic        hit;
  logic [2:0]  idx;
  logic        busy;
  logic [31:0] rd_val;
  logic [15:0] intr_set, intr_clr;
  logic [2:0]  err_set, err_clr;

  // Address decode and read mux, all from current register state so a
  // same-cycle write never leaks into the read data.
  always_comb begin
    off  = addr - BASE;
    hit  = (off[31:5] == 27'd0) && (off[1:0] == 2'b00);
    idx  = off[4:2];
    busy = (state_q == S_RUN);
    case (idx)
      R_INTR:   rd_val = {intr_mask_q, intr_status_q};
      R_CTRL:   rd_val = {15'd0, io_mem_q, w_count_q, 1'b0};
      R_IOADDR: rd_val = io_addr_q;
      R_MEMADR: rd_val = mem_addr_q;
      R_EXTRA:  rd_val = extra_info_q;
      R_STATUS: rd_val = {27'd0, state_q, (state_q == S_ERROR),
                          (state_q == S_DONE), busy};
      R_XCOUNT: rd_val = {16'd0, xfer_count_q};
      default:  rd_val = {29'd0, err_status_q};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    intr_mask_d  = intr_mask_q;
    w_count_d    = w_count_q;
    io_mem_d     = io_mem_q;
    io_addr_d    = io_addr_q;
    mem_addr_d   = mem_addr_q;
    extra_info_d = extra_info_q;
    xfer_count_d = xfer_count_q;
    rdata_d      = rdata_q;
    intr_set     = '0;
    intr_clr     = '0;
    err_set      = '0;
    err_clr      = '0;

    if (busy) begin
      xfer_count_d = xfer_count_q + 16'd1;
      if ((xfer_count_q + 16'd1) == {1'b0, w_count_q}) begin
        state_d     = S_DONE;
        intr_set[0] = 1'b1;
      end
    end

    if (rd_en) begin
      rdata_d = hit ? rd_val : 32'd0;
      if (!hit) err_set[0] = 1'b1;
    end

    if (wr_en) begin
      if (!hit) begin
        err_set[0] = 1'b1;
      end else begin
        case (idx)
          R_INTR: begin
            intr_clr    = wdata[15:0];
            intr_mask_d = wdata[31:16];
          end
          R_CTRL: begin
            if (busy) begin
              err_set[1] = 1'b1;
            end else begin
              w_count_d = wdata[15:1];
              io_mem_d  = wdata[16];
              if (wdata[0]) begin
                if (wdata[15:1] != 15'd0) begin
                  state_d      = S_RUN;
                  xfer_count_d = 16'd0;
                end else begin
                  state_d     = S_ERROR;
                  err_set[2]  = 1'b1;
                  intr_set[1] = 1'b1;
                end
              end
            end
          end
          R_IOADDR: begin
            if (busy) err_set[1] = 1'b1;
            else      io_addr_d  = wdata;
          end
          R_MEMADR: begin
            if (busy) err_set[1] = 1'b1;
            else      mem_addr_d = wdata;
          end
          R_EXTRA:  extra_info_d = wdata;
          R_ERR:    err_clr      = wdata[2:0];
          default:  ;
        endcase
      end
    end

    // Hardware set takes priority over a simultaneous write-one-to-clear.
    intr_status_d = (intr_status_q & ~intr_clr) | intr_set;
    err_status_d  = (err_status_q & ~err_clr) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      intr_status_q <= '0;
      intr_mask_q   <= '0;
      w_count_q     <= '0;
      io_mem_q      <= 1'b0;
      io_addr_q     <= '0;
      mem_addr_q    <= '0;
      extra_info_q  <= '0;
      xfer_count_q  <= '0;
      err_status_q  <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      intr_status_q <= intr_status_d;
      intr_mask_q   <= intr_mask_d;
      w_count_q     <= w_count_d;
      io_mem_q      <= io_mem_d;
      io_addr_q     <= io_addr_d;
      mem_addr_q    <= mem_addr_d;
      extra_info_q  <= extra_info_d;
      xfer_count_q  <= xfer_count_d;
      err_status_q  <= err_status_d;
      rdata_q       <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = |(intr_status_q & intr_mask_q);

endmodule

// File: tb/tb_dma_reg_slave.sv
// Bench for dma_reg_slave: a transaction-level register model checked every
// cycle, plus directed reads with hand-computed literal expectations.
module tb_dma_reg_slave;

  localparam logic [31:0] BASE = 32'h400;
  localparam logic [1:0] PH_IDLE = 2'd0, PH_RUN = 2'd1, PH_DONE = 2'd2, PH_ERR = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dma_reg_slave #(.BASE(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  // Register model state
  logic [15:0] m_ist, m_mask;
  logic [14:0] m_wc;
  logic        m_iomem;
  logic [31:0] m_io, m_mem, m_extra, m_rdata;
  logic [2:0]  m_err;
  logic [1:0]  m_phase;
  int          m_cnt;

  function automatic logic [31:0] m_peek(int idx);
    case (idx)
      0: return {m_mask, m_ist};
      1: return {15'd0, m_iomem, m_wc, 1'b0};
      2: return m_io;
      3: return m_mem;
      4: return m_extra;
      5: return {27'd0, m_phase, m_phase == PH_ERR, m_phase == PH_DONE, m_phase == PH_RUN};
      6: return 32'(m_cnt) & 32'h0000_FFFF;
      default: return {29'd0, m_err};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] off;
    logic        mapped;
    int          idx;
    logic        was_run;
    logic [15:0] iset, iclr;
    logic [2:0]  eset, eclr;
    if (!rst_n) begin
      m_ist = '0; m_mask = '0; m_wc = '0; m_iomem = 1'b0;
      m_io = '0; m_mem = '0; m_extra = '0; m_rdata = '0;
      m_err = '0; m_phase = PH_IDLE; m_cnt = 0;
    end else begin
      off     = addr - BASE;
      mapped  = (off < 32) && (off % 4 == 0);
      idx     = mapped ? int'(off / 4) : 0;
      was_run = (m_phase == PH_RUN);
      iset = '0; iclr = '0; eset = '0; eclr = '0;
      if (rd_en) begin
        m_rdata = mapped ? m_peek(idx) : 32'd0;
        if (!mapped) eset[0] = 1'b1;
      end
      if (was_run) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == int'(m_wc)) begin
          m_phase = PH_DONE;
          iset[0] = 1'b1;
        end
      end
      if (wr_en) begin
        if (!mapped) eset[0] = 1'b1;
        else if ((idx >= 1 && idx <= 3) && was_run) eset[1] = 1'b1;
        else begin
          case (idx)
            0: begin iclr = wdata[15:0]; m_mask = wdata[31:16]; end
            1: begin
              m_wc = wdata[15:1];
              m_iomem = wdata[16];
              if (wdata[0] && m_wc != 0) begin
                m_phase = PH_RUN; m_cnt = 0;
              end else if (wdata[0]) begin
                m_phase = PH_ERR; eset[2] = 1'b1; iset[1] = 1'b1;
              end
            end
            2: m_io = wdata;
            3: m_mem = wdata;
            4: m_extra = wdata;
            7: eclr = wdata[2:0];
            default: ;
          endcase
        end
      end
      m_ist = (m_ist & ~iclr) | iset;
      m_err = (m_err & ~eclr) | eset;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rdata", rdata, m_rdata);
      check("model_irq", {31'd0, irq}, {31'd0, (m_ist & m_mask) != 16'd0});
    end
  end

  task automatic op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] o, input logic [31:0] d);
    op(1'b1, 1'b0, BASE + o, d);
  endtask

  task automatic rd_exp(input logic [31:0] o, input logic [31:0] exp, input string name);
    op(1'b0, 1'b1, BASE + o, 32'd0);
    check(name, rdata, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, BASE, 32'd0);
  endtask

  logic [31:0] st_exp [5] = '{32'h09, 32'h09, 32'h09, 32'h09, 32'h12};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 8; i++) rd_exp(32'(i * 4), 32'd0, "reset_read");
    check("reset_irq", {31'd0, irq}, 32'd0);

    wr(32'h08, 32'hDEAD_BEEF);
    rd_exp(32'h08, 32'hDEAD_BEEF, "io_addr_readback");

    wr(32'h10, 32'h0000_000A);
    op(1'b1, 1'b1, BASE + 32'h10, 32'h0000_000B);
    check("rw_same_cycle_old", rdata, 32'h0000_000A);
    rd_exp(32'h10, 32'h0000_000B, "rw_same_cycle_new");

    // Four-word transfer: busy for exactly four edges after the start write
    wr(32'h00, 32'h0001_0000);
    wr(32'h04, 32'h0001_0009);
    for (int i = 0; i < 5; i++) rd_exp(32'h14, st_exp[i], "status_xfer4");
    rd_exp(32'h18, 32'd4, "xfer_count4");
    rd_exp(32'h04, 32'h0001_0008, "ctrl_readback");
    check("irq_done", {31'd0, irq}, 32'd1);
    rd_exp(32'h00, 32'h0001_0001, "intr_done");
    wr(32'h00, 32'h0001_0001);
    check("irq_w1c", {31'd0, irq}, 32'd0);

    // W1C on the very edge the engine sets done: set must win
    wr(32'h04, 32'h0000_0005);
    idle(1);
    wr(32'h00, 32'h0001_0001);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    rd_exp(32'h00, 32'h0001_0001, "intr_set_wins");
    wr(32'h00, 32'h0001_0001);

    wr(32'h04, 32'h0000_0001);
    rd_exp(32'h14, 32'h0000_001C, "status_zero_count");
    rd_exp(32'h1C, 32'h0000_0004, "err_zero_count");
    rd_exp(32'h00, 32'h0001_0002, "intr_zero_count");
    rd_exp(32'h04, 32'h0000_0000, "ctrl_zero_count");
    check("irq_masked", {31'd0, irq}, 32'd0);

    wr(32'h1C, 32'h7);
    rd_exp(32'h1C, 32'h0, "err_cleared");
    op(1'b0, 1'b1, BASE + 32'h40, 32'd0);
    check("unmapped_read", rdata, 32'd0);
    rd_exp(32'h1C, 32'h1, "err_unmapped");
    wr(32'h1C, 32'h1);
    op(1'b1, 1'b0, BASE + 32'h0A, 32'hFFFF_FFFF);
    rd_exp(32'h08, 32'hDEAD_BEEF, "misaligned_ignored");
    rd_exp(32'h1C, 32'h1, "err_misaligned");
    wr(32'h1C, 32'h1);

    wr(32'h0C, 32'h1234_5678);
    wr(32'h04, 32'h0000_0015);
    wr(32'h0C, 32'hCAFE_F00D);
    wr(32'h10, 32'h0000_0055);
    rd_exp(32'h0C, 32'h1234_5678, "mem_addr_busy");
    rd_exp(32'h1C, 32'h2, "err_busy_write");
    rd_exp(32'h10, 32'h0000_0055, "extra_busy_write");
    idle(8);
    rd_exp(32'h14, 32'h0000_0012, "status_xfer10");
    rd_exp(32'h18, 32'd10, "xfer_count10");

    // Asynchronous reset in the middle of a transfer
    wr(32'h1C, 32'h7);
    wr(32'h00, 32'h0003_0000);
    wr(32'h04, 32'h0000_0015);
    rd_exp(32'h0C, 32'h1234_5678, "pre_reset_read");
    idle(1);
    rst_n = 1'b0;
    #1;
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq_mid", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < 8; i++) rd_exp(32'(i * 4), 32'd0, "post_reset_read");
    check("post_reset_irq", {31'd0, irq}, 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
